// File: rtl/req_ch_arb_queue_if.sv
// Push/select/status bundle for req_ch_arb_queue. The master drives requests and
// the slave is the queue.
interface req_ch_arb_queue_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ID_W   = 4
);
    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                  p_req_val;
    logic [CH_W-1:0]       p_req_ch;
    logic [ID_W-1:0]       p_req_id;
    logic                  p_err_inj;
    logic                  p_arb_val;
    logic [CH_W-1:0]       p_arb_ch;
    logic [(2**ID_W)-1:0]  p_req_id_enb;
    logic                  p_sel_val;
    logic [ID_W-1:0]       p_sel_req_id;
    logic                  p_pe;
    logic [NUM_CH-1:0]     p_lru_ch;
    logic [CNT_W-1:0]      p_count;
    logic                  p_full;
    logic                  p_empty;
    logic                  p_ovf;

    modport master (
        output p_req_val, p_req_ch, p_req_id, p_err_inj, p_arb_val, p_arb_ch, p_req_id_enb,
        input  p_sel_val, p_sel_req_id, p_pe, p_lru_ch, p_count, p_full, p_empty, p_ovf
    );

    modport slave (
        input  p_req_val, p_req_ch, p_req_id, p_err_inj, p_arb_val, p_arb_ch, p_req_id_enb,
        output p_sel_val, p_sel_req_id, p_pe, p_lru_ch, p_count, p_full, p_empty, p_ovf
    );
endinterface

// File: rtl/req_ch_arb_queue.sv
// Compacting in-order request queue with per-channel oldest-first selection,
// id masking, LRU channel hint, per-entry parity and overflow flag.
module req_ch_arb_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ID_W   = 4
) (
    input logic              clk,
    input logic              rst,
    req_ch_arb_queue_if.slave bus
);
    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] val_q, val_d;
    logic [CH_W-1:0]  ch_q [DEPTH];
    logic [CH_W-1:0]  ch_d [DEPTH];
    logic [ID_W-1:0]  id_q [DEPTH];
    logic [ID_W-1:0]  id_d [DEPTH];
    logic [DEPTH-1:0] ep_q, ep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  order_q [NUM_CH];
    logic [CH_W-1:0]  order_d [NUM_CH];
    logic             sel_val_q, sel_val_d, pe_q, pe_d, ovf_q, ovf_d;
    logic [ID_W-1:0]  sel_id_q, sel_id_d;

    logic             win, full, push_ok, shift;
    logic [IDX_W-1:0] win_idx, wr_idx;
    logic [NUM_CH-1:0] elig, lru;
    logic             found;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign push_ok = bus.p_req_val && !full;
    assign wr_idx  = IDX_W'(cnt_q - CNT_W'(win));

    // Oldest eligible entry of the requested channel.
    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (bus.p_arb_val && val_q[k] && ch_q[k] == bus.p_arb_ch &&
                bus.p_req_id_enb[id_q[k]]) begin
                win     = 1'b1;
                win_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        val_d = val_q;
        ep_d  = ep_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ch_d[i] = ch_q[i];
            id_d[i] = id_q[i];
        end
        if (win) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                if (i >= int'(win_idx)) begin
                    val_d[i] = val_q[i+1];
                    ch_d[i]  = ch_q[i+1];
                    id_d[i]  = id_q[i+1];
                    ep_d[i]  = ep_q[i+1];
                end
            end
            val_d[DEPTH-1] = 1'b0;
        end
        // Push lands after the compaction, so it can never win this cycle.
        if (push_ok) begin
            val_d[wr_idx] = 1'b1;
            ch_d[wr_idx]  = bus.p_req_ch;
            id_d[wr_idx]  = bus.p_req_id;
            ep_d[wr_idx]  = (^{bus.p_req_ch, bus.p_req_id}) ^ bus.p_err_inj;
        end
        cnt_d     = cnt_q + CNT_W'(push_ok) - CNT_W'(win);
        sel_val_d = win;
        sel_id_d  = win ? id_q[win_idx] : '0;
        pe_d      = win ? ((^{ch_q[win_idx], id_q[win_idx]}) != ep_q[win_idx]) : 1'b0;
        ovf_d     = bus.p_req_val && full;
    end

    // order_q[0] is least recently served; the served channel moves to the tail.
    always_comb begin
        shift = 1'b0;
        for (int j = 0; j < int'(NUM_CH); j++) order_d[j] = order_q[j];
        if (win) begin
            for (int j = 0; j < int'(NUM_CH) - 1; j++) begin
                if (order_q[j] == bus.p_arb_ch) shift = 1'b1;
                if (shift) order_d[j] = order_q[j+1];
            end
            order_d[NUM_CH-1] = bus.p_arb_ch;
        end
    end

    always_comb begin
        elig  = '0;
        lru   = '0;
        found = 1'b0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (val_q[i] && ch_q[i] == CH_W'(c) && bus.p_req_id_enb[id_q[i]]) elig[c] = 1'b1;
            end
        end
        for (int j = 0; j < int'(NUM_CH); j++) begin
            if (!found && elig[order_q[j]]) begin
                lru[order_q[j]] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q     <= '0;
            ep_q      <= '0;
            cnt_q     <= '0;
            sel_val_q <= 1'b0;
            sel_id_q  <= '0;
            pe_q      <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ch_q[i] <= '0;
                id_q[i] <= '0;
            end
            for (int j = 0; j < int'(NUM_CH); j++) order_q[j] <= CH_W'(j);
        end else begin
            val_q     <= val_d;
            ep_q      <= ep_d;
            cnt_q     <= cnt_d;
            sel_val_q <= sel_val_d;
            sel_id_q  <= sel_id_d;
            pe_q      <= pe_d;
            ovf_q     <= ovf_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ch_q[i] <= ch_d[i];
                id_q[i] <= id_d[i];
            end
            for (int j = 0; j < int'(NUM_CH); j++) order_q[j] <= order_d[j];
        end
    end

    assign bus.p_sel_val    = sel_val_q;
    assign bus.p_sel_req_id = sel_id_q;
    assign bus.p_pe         = pe_q;
    assign bus.p_ovf        = ovf_q;
    assign bus.p_lru_ch     = lru;
    assign bus.p_count      = cnt_q;
    assign bus.p_full       = full;
    assign bus.p_empty      = (cnt_q == '0);
endmodule

// File: tb/tb_req_ch_arb_queue.sv
// Directed bench for req_ch_arb_queue: stimulus queues expected registered
// responses, a negedge monitor pops and compares them.
module tb_req_ch_arb_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    req_ch_arb_queue_if #(.DEPTH(16), .NUM_CH(4), .ID_W(4)) bus ();

    req_ch_arb_queue #(.DEPTH(16), .NUM_CH(4), .ID_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    due;
        string name;
        bit    sv;
        int    id;
        bit    pe;
        bit    ovf;
        int    cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every registered response that has become due.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            chk({mon_e.name, ".sel_val"}, 32'(bus.p_sel_val), 32'(mon_e.sv));
            chk({mon_e.name, ".sel_id"}, 32'(bus.p_sel_req_id), 32'(mon_e.id));
            chk({mon_e.name, ".pe"}, 32'(bus.p_pe), 32'(mon_e.pe));
            chk({mon_e.name, ".ovf"}, 32'(bus.p_ovf), 32'(mon_e.ovf));
            chk({mon_e.name, ".count"}, 32'(bus.p_count), 32'(mon_e.cnt));
        end
    end

    task automatic step(input string name, input bit rv, input int rch, input int rid,
                        input bit err, input bit av, input int ach, input logic [15:0] enb,
                        input bit esv, input int eid, input bit epe, input bit eovf,
                        input int ecnt);
        exp_t e;
        bus.p_req_val    = rv;
        bus.p_req_ch     = 2'(rch);
        bus.p_req_id     = 4'(rid);
        bus.p_err_inj    = err;
        bus.p_arb_val    = av;
        bus.p_arb_ch     = 2'(ach);
        bus.p_req_id_enb = enb;
        e = '{due: cyc + 1, name: name, sv: esv, id: eid, pe: epe, ovf: eovf, cnt: ecnt};
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.p_req_val = 1'b0;
        bus.p_arb_val = 1'b0;
        bus.p_err_inj = 1'b0;
    endtask

    task automatic push(input string name, input int ch, input int id, input bit err,
                        input int ecnt);
        step(name, 1'b1, ch, id, err, 1'b0, 0, 16'hFFFF, 1'b0, 0, 1'b0, 1'b0, ecnt);
    endtask

    task automatic arb(input string name, input int ch, input logic [15:0] enb, input bit esv,
                       input int eid, input bit epe, input int ecnt);
        step(name, 1'b0, 0, 0, 1'b0, 1'b1, ch, enb, esv, eid, epe, 1'b0, ecnt);
    endtask

    task automatic lru_chk(input string name, input logic [15:0] enb, input logic [3:0] exp);
        bus.p_req_id_enb = enb;
        #1;
        chk(name, 32'(bus.p_lru_ch), 32'(exp));
        bus.p_req_id_enb = 16'hFFFF;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bus.p_req_val    = 1'b0;
        bus.p_req_ch     = '0;
        bus.p_req_id     = '0;
        bus.p_err_inj    = 1'b0;
        bus.p_arb_val    = 1'b0;
        bus.p_arb_ch     = '0;
        bus.p_req_id_enb = 16'hFFFF;
        #12;
        chk("reset.count", 32'(bus.p_count), 0);
        chk("reset.empty", 32'(bus.p_empty), 1);
        chk("reset.full", 32'(bus.p_full), 0);
        chk("reset.sel_val", 32'(bus.p_sel_val), 0);
        chk("reset.ovf", 32'(bus.p_ovf), 0);
        chk("reset.lru", 32'(bus.p_lru_ch), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic push and oldest-first select.
        push("s1.push0", 1, 0, 1'b0, 1);
        push("s1.push1", 0, 1, 1'b0, 2);
        push("s1.push2", 1, 2, 1'b0, 3);
        lru_chk("s1.lru", 16'hFFFF, 4'b0001);
        arb("s1.arb_ch1", 1, 16'hFFFF, 1'b1, 0, 1'b0, 2);
        // Masked ids: no selection, and the hint skips masked entries.
        arb("s2.arb_masked", 1, 16'hFFFB, 1'b0, 0, 1'b0, 2);
        lru_chk("s2.lru_mask_id1", 16'hFFFD, 4'b0010);
        arb("s2.arb_ch1", 1, 16'hFFFF, 1'b1, 2, 1'b0, 1);
        arb("s2.arb_ch0", 0, 16'hFFFF, 1'b1, 1, 1'b0, 0);
        chk("s2.empty", 32'(bus.p_empty), 1);

        // Parity error injection.
        push("s4.push_err", 2, 3, 1'b1, 1);
        arb("s4.arb_err", 2, 16'hFFFF, 1'b1, 3, 1'b1, 0);
        push("s4.push_ok", 2, 3, 1'b0, 1);
        arb("s4.arb_ok", 2, 16'hFFFF, 1'b1, 3, 1'b0, 0);
        arb("s4.arb_empty", 2, 16'hFFFF, 1'b0, 0, 1'b0, 0);

        // LRU ordering, same-cycle push+pop, same-cycle push not eligible.
        do_reset();
        push("s5.push_c0", 0, 5, 1'b0, 1);
        push("s5.push_c3", 3, 6, 1'b0, 2);
        lru_chk("s5.lru_before", 16'hFFFF, 4'b0001);
        arb("s5.arb_ch0", 0, 16'hFFFF, 1'b1, 5, 1'b0, 1);
        lru_chk("s5.lru_after", 16'hFFFF, 4'b1000);
        push("s5.push_c0b", 0, 7, 1'b0, 2);
        lru_chk("s5.lru_order", 16'hFFFF, 4'b1000);
        step("s5.push_pop", 1'b1, 1, 8, 1'b0, 1'b1, 3, 16'hFFFF, 1'b1, 6, 1'b0, 1'b0, 2);
        lru_chk("s5.lru_ch1", 16'hFFFF, 4'b0010);
        arb("s5.arb_ch1", 1, 16'hFFFF, 1'b1, 8, 1'b0, 1);
        arb("s5.arb_ch0b", 0, 16'hFFFF, 1'b1, 7, 1'b0, 0);
        step("s5.push_same", 1'b1, 2, 9, 1'b0, 1'b1, 2, 16'hFFFF, 1'b0, 0, 1'b0, 1'b0, 1);
        arb("s5.arb_ch2", 2, 16'hFFFF, 1'b1, 9, 1'b0, 0);

        // Fill to full, then overflow alongside a successful select.
        do_reset();
        for (int i = 0; i < 16; i++) push($sformatf("s3.fill%0d", i), i % 4, i, 1'b0, i + 1);
        chk("s3.full", 32'(bus.p_full), 1);
        chk("s3.not_empty", 32'(bus.p_empty), 0);
        step("s3.ovf_pop", 1'b1, 1, 15, 1'b0, 1'b1, 0, 16'hFFFF, 1'b1, 0, 1'b0, 1'b1, 15);
        step("s3.idle", 1'b0, 0, 0, 1'b0, 1'b0, 0, 16'hFFFF, 1'b0, 0, 1'b0, 1'b0, 15);
        chk("s3.not_full", 32'(bus.p_full), 0);
        arb("s3.arb_mask4", 0, 16'hFFEF, 1'b1, 8, 1'b0, 14);

        // Asynchronous reset with entries held and a selection showing.
        do_reset();
        for (int i = 0; i < 6; i++) push($sformatf("s6.push%0d", i), i % 4, i + 1, 1'b0, i + 1);
        arb("s6.arb_ch1", 1, 16'hFFFF, 1'b1, 2, 1'b0, 5);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("s6.count", 32'(bus.p_count), 0);
        chk("s6.empty", 32'(bus.p_empty), 1);
        chk("s6.full", 32'(bus.p_full), 0);
        chk("s6.sel_val", 32'(bus.p_sel_val), 0);
        chk("s6.sel_id", 32'(bus.p_sel_req_id), 0);
        chk("s6.pe", 32'(bus.p_pe), 0);
        chk("s6.ovf", 32'(bus.p_ovf), 0);
        chk("s6.lru", 32'(bus.p_lru_ch), 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
